// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
// Walks the register file read port through every index once per start pulse
// and streams each register out as an (index, data) beat on a valid/ready port.
// All outputs are registered; reset is asynchronous and active low.
module regfile_dump_reader #(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter bit          SKIP_ZERO = 1'b0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    // The walk ends on NUM_REGS-1, not on the top of the index range,
    // so a non power-of-two register count never wraps idx.
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(SKIP_ZERO ? 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] idx;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; abort outranks out_ready and start
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    next_state = ST_READ;
                end
            end
            ST_READ: begin
                next_state = abort ? ST_IDLE : ST_SEND;
            end
            ST_SEND: begin
                if (abort) begin
                    next_state = ST_IDLE;
                end else if (out_ready) begin
                    next_state = (idx == LAST_IDX) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Registered outputs and walk index, updated from the current state and
    // the decided next state so busy/done line up with the state they describe
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            rf_addr   <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy <= (next_state == ST_READ) || (next_state == ST_SEND);
            done <= (next_state == ST_DONE);
            unique case (state)
                ST_IDLE: begin
                    if (next_state == ST_READ) begin
                        idx     <= FIRST_IDX;
                        rf_addr <= FIRST_IDX;
                    end else begin
                        rf_addr <= '0;
                    end
                end
                ST_READ: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        rf_addr   <= '0;
                    end else begin
                        out_data  <= rf_data;
                        out_index <= idx;
                        out_valid <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        rf_addr   <= '0;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx != LAST_IDX) begin
                            idx     <= idx + 1'b1;
                            rf_addr <= idx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    rf_addr <= '0;
                end
            endcase
        end
    end

endmodule
